read_square: RTL and testbench
==============================

READ_SQUARE -- requirements
Module: read_square

Interface
REQ-001: clock  input  1  single system clock; all state updates on rising edge.
REQ-002: resetn  input  1  reset is asynchronous and active-low.
REQ-003: start  input  1  request to read one 4x4 square; sampled only in IDLE.
REQ-004: x  input  9  top-left column of square; latched in LOAD.
REQ-005: y  input  8  top-left row of square; latched in LOAD.
REQ-006: mem_x  output  9  framebuffer read column.
REQ-007: mem_y  output  8  framebuffer read row.
REQ-008: mem_read  output  1  framebuffer read strobe; one pixel address per cycle.
REQ-009: mem_colour  input  3  framebuffer read data; valid exactly one cycle after the mem_read cycle.
REQ-010: pixels  output  48  captured square; pixel i (i = 4*row + col) at bits [3i+2:3i].
REQ-011: busy  output  1  high in every state except IDLE.
REQ-012: done  output  1  one-cycle pulse when pixels is complete.
REQ-013: hit  output  1  present only when READ_SQUARE_HIT_EN is defined (see Configuration).

Function
REQ-014: FSM states IDLE, LOAD, READ, DRAIN, DONE; IDLE->LOAD on start, LOAD->READ, READ->READ while counter<15, READ->DRAIN at counter=15, DRAIN->DONE, DONE->IDLE.
REQ-015: LOAD latches x, y into base registers and clears the 4-bit counter.
REQ-016: READ asserts mem_read; counter increments by 1 each READ cycle, 16 READ cycles total.
REQ-017: mem_x = x_base + counter[1:0], mem_y = y_base + counter[3:2], combinational from registers, truncated to 9/8 bits (wrap modulo 512/256, no clamping).
REQ-018: mem_x, mem_y drive 0 and mem_read drives 0 outside READ.
REQ-019: a one-cycle-delayed valid/index pipeline captures mem_colour into pixels slot i on the edge ending the cycle after the READ cycle with counter=i; last capture (i=15) occurs at end of DRAIN.
REQ-020: pixels slots not yet captured in the current operation retain their previous values; pixels holds steady from DONE until the next capture.
REQ-021: start sampled high at edge E0 -> done high for exactly the cycle between edges E0+18 and E0+19; busy high from E0 to E0+19.
REQ-022: start asserted while busy is ignored; start held high continuously launches a new operation each time IDLE is re-entered (one IDLE cycle between operations).
REQ-023: x, y changes after LOAD have no effect on the operation in progress.
REQ-024: done and mem_read are never high in the same cycle.

Reset
REQ-025: resetn low forces, without waiting for clock, state=IDLE, counter=0, base registers=0, pixel pipeline valid=0, pixels=0, done=0, busy=0, mem_read=0, hit=0.
REQ-026: resetn asserted mid-operation aborts it; no done is produced for the aborted operation; first start after resetn deassertion behaves per REQ-021.

Configuration
REQ-027: macro READ_SQUARE_HIT_EN defined: hit port exists; hit cleared in LOAD, set on any capture of mem_colour != 3'b000, valid in DONE and held until next LOAD.
REQ-028: macro READ_SQUARE_HIT_EN undefined: hit port and its logic are absent; all other behaviour identical.

Verification
REQ-029: x=9'd10, y=8'd20, start 1 cycle -> 16 mem_read cycles, addresses (10,20),(11,20),(12,20),(13,20),(10,21)...(13,23) in order; done at E0+18.
REQ-030: model returns mem_colour = i[2:0] for pixel i -> pixels = {3'd7,3'd6,...,3'd0,3'd7,...,3'd0} (slot i = i mod 8).
REQ-031: x=9'd510, y=8'd255 -> mem_x sequence 510,511,0,1; mem_y sequence 255,0,1,2 (wrap).
REQ-032: start pulsed at E0+5 during operation -> ignored, single done; start held high -> back-to-back operations, done spacing 20 cycles.
REQ-033: resetn low at E0+8 -> immediate IDLE, pixels=0, no done; restart completes normally.
REQ-034: with READ_SQUARE_HIT_EN: all-zero memory -> hit=0 at done; only pixel 15 = 3'd4 -> hit=1 at done, hit=0 after next LOAD.

Source files
------------

// File: rtl/read_square_if.sv
// Handshake and framebuffer bus bundle for read_square.
// The hit signal exists only when READ_SQUARE_HIT_EN is defined.
interface read_square_if;
   logic        start;
   logic [8:0]  x;
   logic [7:0]  y;
   logic [8:0]  mem_x;
   logic [7:0]  mem_y;
   logic        mem_read;
   logic [2:0]  mem_colour;
   logic [47:0] pixels;
   logic        busy;
   logic        done;
`ifdef READ_SQUARE_HIT_EN
   logic        hit;
`endif

   // Requester side: issues start/x/y and supplies framebuffer read data.
   modport master (
      output start, x, y, mem_colour,
      input  mem_x, mem_y, mem_read, pixels, busy, done
`ifdef READ_SQUARE_HIT_EN
      , input hit
`endif
   );

   // Reader side: the read_square engine.
   modport slave (
      input  start, x, y, mem_colour,
      output mem_x, mem_y, mem_read, pixels, busy, done
`ifdef READ_SQUARE_HIT_EN
      , output hit
`endif
   );
endinterface

// File: rtl/read_square.sv
// Reads a 4x4 pixel square from a framebuffer (one address per cycle) and packs it into 48 bits.
// Optional feature: define READ_SQUARE_HIT_EN to add the hit flag (any non-black pixel captured).
module read_square (
   input  logic          i_clock,
   input  logic          i_resetn,
   read_square_if.slave  io_bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [8:0]  r_x_base;
   logic [7:0]  r_y_base;
   logic        r_pipe_vld;
   logic [3:0]  r_pipe_idx;
   logic [47:0] r_pixels;
   logic        r_busy;
   logic        r_done;
`ifdef READ_SQUARE_HIT_EN
   logic        r_hit;
`endif

   logic        w_reading;
   logic [5:0]  w_slot_lsb;

   assign w_reading  = (r_state == S_READ);
   assign w_slot_lsb = {2'b00, r_pipe_idx} * 6'd3;

   // Read data returns one cycle after the address, so capture uses the delayed index.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_x_base   <= 9'd0;
         r_y_base   <= 8'd0;
         r_pipe_vld <= 1'b0;
         r_pipe_idx <= 4'd0;
         r_pixels   <= 48'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef READ_SQUARE_HIT_EN
         r_hit      <= 1'b0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_pipe_vld <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (io_bus.start) begin
                  r_state <= S_LOAD;
                  r_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               r_x_base <= io_bus.x;
               r_y_base <= io_bus.y;
               r_cnt    <= 4'd0;
               r_state  <= S_READ;
`ifdef READ_SQUARE_HIT_EN
               r_hit    <= 1'b0;
`endif
            end
            S_READ: begin
               r_pipe_vld <= 1'b1;
               r_pipe_idx <= r_cnt;
               r_cnt      <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         if (r_pipe_vld) begin
            r_pixels[w_slot_lsb +: 3] <= io_bus.mem_colour;
`ifdef READ_SQUARE_HIT_EN
            if (io_bus.mem_colour != 3'b000) begin
               r_hit <= 1'b1;
            end
`endif
         end
      end
   end

   // Addresses wrap naturally at the 9/8-bit widths; idle cycles drive zero.
   assign io_bus.mem_x    = w_reading ? 9'(r_x_base + {7'd0, r_cnt[1:0]}) : 9'd0;
   assign io_bus.mem_y    = w_reading ? 8'(r_y_base + {6'd0, r_cnt[3:2]}) : 8'd0;
   assign io_bus.mem_read = w_reading;
   assign io_bus.pixels   = r_pixels;
   assign io_bus.busy     = r_busy;
   assign io_bus.done     = r_done;
`ifdef READ_SQUARE_HIT_EN
   assign io_bus.hit      = r_hit;
`endif

endmodule

// File: tb/tb_read_square.sv
// Scoreboard bench for read_square: expected addresses/pixels are queued at launch and popped as the DUT responds.
module tb_read_square;

   logic clk;
   logic resetn;
   int   n_cmp;
   int   n_fail;

   read_square_if sq ();

   read_square dut (
      .i_clock  (clk),
      .i_resetn (resetn),
      .io_bus   (sq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
   } addr_t;

   addr_t       aq[$];
   logic [47:0] pq[$];
`ifdef READ_SQUARE_HIT_EN
   bit          hq[$];
`endif

   logic [8:0]  cur_bx;
   logic [7:0]  cur_by;
   int          cur_mode;
   logic [47:0] last_pix;

   function automatic logic [2:0] colour_of(input int mode, input logic [3:0] idx);
      case (mode)
         0:       return idx[2:0];
         1:       return 3'((int'(idx) * 5 + 3) % 8);
         2:       return 3'd0;
         default: return (idx == 4'd15) ? 3'd4 : 3'd0;
      endcase
   endfunction

   function automatic logic [47:0] pix_of(input int mode);
      logic [47:0] p;
      p = '0;
      for (int i = 0; i < 16; i++) p[3*i +: 3] = colour_of(mode, 4'(i));
      return p;
   endfunction

   // Framebuffer model: colour depends on the address offset from the square origin.
   always @(posedge clk) begin : mem_model
      logic [8:0] dx;
      logic [7:0] dy;
      if (sq.mem_read === 1'b1) begin
         dx = sq.mem_x - cur_bx;
         dy = sq.mem_y - cur_by;
         sq.mem_colour <= colour_of(cur_mode, {dy[1:0], dx[1:0]});
      end else begin
         sq.mem_colour <= 3'($urandom);
      end
   end

   task automatic push_op(input logic [8:0] bx, input logic [7:0] by, input int mode);
      addr_t a;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            a.x = 9'(bx + 9'(c));
            a.y = 8'(by + 8'(r));
            aq.push_back(a);
         end
      end
      pq.push_back(pix_of(mode));
`ifdef READ_SQUARE_HIT_EN
      hq.push_back(pix_of(mode) != 48'd0);
`endif
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      sq.start = 1'b0;
      sq.x     = '0;
      sq.y     = '0;
      last_pix = '0;
      cur_bx = '0; cur_by = '0; cur_mode = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if (sq.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", sq.busy); end
      n_cmp++; if (sq.done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got=%b exp=0", sq.done); end
      n_cmp++; if (sq.mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got=%b exp=0", sq.mem_read); end
      n_cmp++; if (sq.pixels !== 48'd0)  begin n_fail++; $display("FAIL reset_pixels got=%h exp=0", sq.pixels); end
      n_cmp++; if ({sq.mem_x, sq.mem_y} !== 17'd0) begin n_fail++; $display("FAIL reset_addr got=%0d,%0d exp=0,0", sq.mem_x, sq.mem_y); end
`ifdef READ_SQUARE_HIT_EN
      n_cmp++; if (sq.hit !== 1'b0)      begin n_fail++; $display("FAIL reset_hit got=%b exp=0", sq.hit); end
`endif
      resetn = 1'b1;
      @(negedge clk);
      $display("reset checked");
   endtask

   // One operation launched at edge E0; k counts the cycle between E0+k and E0+k+1.
   task automatic do_op(input logic [8:0] bx, input logic [7:0] by, input int mode,
                        input int pulse_k, input int abort_k);
      logic [47:0] exp_ret;
      logic [47:0] exp_pix;
      addr_t       a;
      int          n_done;
      int          done_k;
      bit          exp_rd;
`ifdef READ_SQUARE_HIT_EN
      bit          exp_hit;
`endif
      cur_bx = bx; cur_by = by; cur_mode = mode;
      push_op(bx, by, mode);
      exp_ret = last_pix;
      exp_ret[2:0] = colour_of(mode, 4'd0);
      n_done = 0;
      done_k = -1;
      @(negedge clk);
      sq.start = 1'b1; sq.x = bx; sq.y = by;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (k == 0) sq.start = 1'b0;
         if (k == 1) begin sq.x = 9'($urandom); sq.y = 8'($urandom); end
         if (k == pulse_k) sq.start = 1'b1;
         if (k == pulse_k + 1) sq.start = 1'b0;

         n_cmp++;
         if (sq.busy !== (k <= 18)) begin n_fail++; $display("FAIL busy k=%0d got=%b exp=%b", k, sq.busy, (k <= 18)); end
         exp_rd = (k >= 1) && (k <= 16);
         n_cmp++;
         if (sq.mem_read !== exp_rd) begin n_fail++; $display("FAIL mem_read k=%0d got=%b exp=%b", k, sq.mem_read, exp_rd); end
         if (sq.mem_read === 1'b1) begin
            n_cmp++;
            if (aq.size() == 0) begin
               n_fail++; $display("FAIL extra_read k=%0d got=%0d,%0d exp=none", k, sq.mem_x, sq.mem_y);
            end else begin
               a = aq.pop_front();
               if ({sq.mem_x, sq.mem_y} !== {a.x, a.y}) begin
                  n_fail++; $display("FAIL addr k=%0d got=%0d,%0d exp=%0d,%0d", k, sq.mem_x, sq.mem_y, a.x, a.y);
               end
            end
         end else begin
            n_cmp++;
            if ({sq.mem_x, sq.mem_y} !== 17'd0) begin n_fail++; $display("FAIL idle_addr k=%0d got=%0d,%0d exp=0,0", k, sq.mem_x, sq.mem_y); end
         end
         n_cmp++;
         if (sq.done !== (k == 18)) begin n_fail++; $display("FAIL done_timing k=%0d got=%b exp=%b", k, sq.done, (k == 18)); end
         if (sq.done === 1'b1) begin
            n_done++;
            done_k = k;
            n_cmp++;
            if (pq.size() == 0) begin
               n_fail++; $display("FAIL extra_done k=%0d got=1 exp=0", k);
            end else begin
               exp_pix = pq.pop_front();
               if (sq.pixels !== exp_pix) begin n_fail++; $display("FAIL pixels got=%h exp=%h", sq.pixels, exp_pix); end
            end
`ifdef READ_SQUARE_HIT_EN
            exp_hit = (hq.size() != 0) ? hq.pop_front() : 1'b0;
            n_cmp++;
            if (sq.hit !== exp_hit) begin n_fail++; $display("FAIL hit_at_done got=%b exp=%b", sq.hit, exp_hit); end
`endif
         end
`ifdef READ_SQUARE_HIT_EN
         if (k == 2) begin
            n_cmp++;
            if (sq.hit !== 1'b0) begin n_fail++; $display("FAIL hit_after_load got=%b exp=0", sq.hit); end
         end
`endif
         if (k == 3) begin
            n_cmp++;
            if (sq.pixels !== exp_ret) begin n_fail++; $display("FAIL retain got=%h exp=%h", sq.pixels, exp_ret); end
         end
         if (k == abort_k) begin
            resetn = 1'b0;
            #1;
            n_cmp++; if (sq.busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy got=%b exp=0", sq.busy); end
            n_cmp++; if (sq.mem_read !== 1'b0) begin n_fail++; $display("FAIL abort_mem_read got=%b exp=0", sq.mem_read); end
            n_cmp++; if (sq.pixels !== 48'd0)  begin n_fail++; $display("FAIL abort_pixels got=%h exp=0", sq.pixels); end
            n_cmp++; if (sq.done !== 1'b0)     begin n_fail++; $display("FAIL abort_done got=%b exp=0", sq.done); end
            aq.delete(); pq.delete();
`ifdef READ_SQUARE_HIT_EN
            hq.delete();
`endif
            last_pix = '0;
            @(negedge clk);
            resetn = 1'b1;
            $display("op x=%0d y=%0d mode=%0d aborted at k=%0d", bx, by, mode, k);
            return;
         end
      end
      n_cmp++;
      if (n_done != 1 || aq.size() != 0) begin
         n_fail++; $display("FAIL op_complete dones=%0d left_reads=%0d exp=1,0", n_done, aq.size());
      end
      aq.delete(); pq.delete();
`ifdef READ_SQUARE_HIT_EN
      hq.delete();
`endif
      last_pix = pix_of(mode);
      $display("op x=%0d y=%0d mode=%0d done_k=%0d pixels=%h", bx, by, mode, done_k, sq.pixels);
   endtask

   task automatic test_basic();
      do_op(9'd10, 8'd20, 0, -5, -5);
      do_op(9'd300, 8'd100, 1, -5, -5);
   endtask

   task automatic test_wrap();
      do_op(9'd510, 8'd255, 1, -5, -5);
   endtask

   task automatic test_start_ignored();
      do_op(9'd40, 8'd7, 0, 4, -5);
   endtask

   task automatic test_abort();
      do_op(9'd10, 8'd20, 1, -5, 7);
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         n_cmp++;
         if (sq.done !== 1'b0 || sq.busy !== 1'b0) begin
            n_fail++; $display("FAIL post_abort k=%0d got done=%b busy=%b exp=0,0", k, sq.done, sq.busy);
         end
      end
      do_op(9'd10, 8'd20, 0, -5, -5);
   endtask

   task automatic test_hit();
      do_op(9'd0, 8'd0, 2, -5, -5);
      do_op(9'd64, 8'd32, 3, -5, -5);
      do_op(9'd64, 8'd32, 2, -5, -5);
   endtask

   task automatic test_back_to_back();
      addr_t       a;
      logic [47:0] exp_pix;
      int          d[$];
      cur_bx = 9'd200; cur_by = 8'd50; cur_mode = 1;
      push_op(cur_bx, cur_by, 1);
      push_op(cur_bx, cur_by, 1);
      @(negedge clk);
      sq.start = 1'b1; sq.x = cur_bx; sq.y = cur_by;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (k == 20) sq.start = 1'b0;
         if (sq.mem_read === 1'b1) begin
            n_cmp++;
            if (aq.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra_read k=%0d got=%0d,%0d exp=none", k, sq.mem_x, sq.mem_y);
            end else begin
               a = aq.pop_front();
               if ({sq.mem_x, sq.mem_y} !== {a.x, a.y}) begin
                  n_fail++; $display("FAIL b2b_addr k=%0d got=%0d,%0d exp=%0d,%0d", k, sq.mem_x, sq.mem_y, a.x, a.y);
               end
            end
         end
         if (sq.done === 1'b1) begin
            d.push_back(k);
            n_cmp++;
            exp_pix = (pq.size() != 0) ? pq.pop_front() : 48'd0;
            if (sq.pixels !== exp_pix) begin n_fail++; $display("FAIL b2b_pixels got=%h exp=%h", sq.pixels, exp_pix); end
         end
      end
      n_cmp++;
      if (d.size() != 2) begin
         n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", d.size());
      end else begin
         n_cmp++;
         if (d[0] != 18 || d[1] - d[0] != 20) begin
            n_fail++; $display("FAIL b2b_spacing got first=%0d gap=%0d exp first=18 gap=20", d[0], d[1] - d[0]);
         end
      end
      n_cmp++;
      if (aq.size() != 0) begin n_fail++; $display("FAIL b2b_left_reads got=%0d exp=0", aq.size()); end
      aq.delete(); pq.delete();
`ifdef READ_SQUARE_HIT_EN
      hq.delete();
`endif
      last_pix = pix_of(1);
      $display("back_to_back dones=%0d", d.size());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_start_ignored();
      test_abort();
      test_hit();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
